sys_ctrl_tx_seq: RTL and testbench
==================================

# sys_ctrl_tx_seq

Transmit-side sequencer of the system controller. It consumes register-file read responses (8-bit) and ALU results (16-bit), buffers one response, and feeds it byte by byte to the UART transmitter through a valid/busy handshake. It sits between the register file and ALU outputs and the UART TX parallel input. It is the return path for the frames decoded by the receive-side controller.

## Interface
Parameters:
- DATA_W, default 8: byte width toward UART TX and register-file read data.
- ALU_W, default 16: ALU result width; always 2*DATA_W.
- ACK_TIMEOUT, default 255: number of cycles to wait for TX_Busy to rise after a byte is issued.

Ports:
- CLK, in, 1: system clock. One clock domain.
- RST, in, 1: asynchronous, active-low reset.
- RdData, in, DATA_W: register-file read data.
- RdData_Valid, in, 1: single-cycle strobe qualifying RdData.
- ALU_OUT, in, ALU_W: ALU result.
- OUT_Valid, in, 1: single-cycle strobe qualifying ALU_OUT.
- TX_Busy, in, 1: UART TX busy. Already synchronized into CLK.
- TX_P_DATA, out, DATA_W: byte to transmit. Registered.
- TX_D_VLD, out, 1: one-cycle strobe for TX_P_DATA. Registered.
- Ctrl_Busy, out, 1: high whenever the state is not IDLE.
- Drop_Err, out, 1: sticky. Set when an incoming response is discarded.
- Tx_Err, out, 1: sticky. Set when an ACK timeout occurs.

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If OUT_Valid: load hold[15:0] = ALU_OUT, set nbytes = 2, idx = 0, go to ISSUE.
  - Else if RdData_Valid: load hold[7:0] = RdData, set hold[15:8] = 0, nbytes = 1, idx = 0, go to ISSUE.
  - If both strobes arrive in the same cycle, the ALU result wins, the read data is discarded and Drop_Err is set.
- ISSUE:
  - If TX_Busy = 0: TX_P_DATA <= byte idx of hold (idx 0 = bits 7:0, idx 1 = bits 15:8), TX_D_VLD <= 1, clear the timer, go to WAIT_ACK.
  - If TX_Busy = 1: stay in ISSUE.
- WAIT_ACK:
  - If TX_Busy = 1: go to WAIT_DONE.
  - Else the timer increments. When it reaches ACK_TIMEOUT, set Tx_Err and proceed as if WAIT_DONE had completed (do not resend the byte).
- WAIT_DONE:
  - When TX_Busy = 0: if idx+1 < nbytes, increment idx and go to ISSUE; otherwise go to IDLE.
- Any RdData_Valid or OUT_Valid seen while the state is not IDLE is discarded and sets Drop_Err. The hold register is left unchanged.
- Drop_Err and Tx_Err clear only on reset.
- Byte order: low byte first.

## Timing
- Reset values:
  - State = IDLE.
  - TX_P_DATA = 0, TX_D_VLD = 0.
  - Ctrl_Busy = 0, Drop_Err = 0, Tx_Err = 0.
  - hold = 0, idx = 0, timer = 0.
- Latency: a strobe sampled at clock edge k produces TX_D_VLD high during the cycle after edge k+1, provided TX_Busy = 0 at edge k+1.
- TX_D_VLD is high for exactly one cycle per byte and is never asserted while TX_Busy = 1.
- TX_P_DATA holds its value from issue until the next issue.
- Ctrl_Busy rises in the cycle after the capturing edge. It falls in the cycle after the edge at which TX_Busy is sampled low in WAIT_DONE for the last byte.
- Minimum gap between the two bytes of an ALU result: 2 cycles after TX_Busy falls (WAIT_DONE, then ISSUE).
- Timeout: Tx_Err rises ACK_TIMEOUT cycles after TX_D_VLD if TX_Busy never rose.
- Timer width: clog2(ACK_TIMEOUT+1). It saturates and does not wrap.
- Reset mid-transfer: asynchronous return to IDLE with all outputs at their reset values. The partial response is lost and no further strobes are issued.

## Structure
- Shared package `sys_ctrl_pkg`:
  - state enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE);
  - DATA_W and ALU_W defaults;
  - byte-index width constant.
- One sub-module, `tx_ack_timer`: a clearable, saturating up-counter with a terminal-count output, parameterized by ACK_TIMEOUT.
- Everything else stays in a single FSM file.

## Test plan
- RdData = 8'h5A with a one-cycle valid, TX_Busy modelled as rising 1 cycle after TX_D_VLD and held 10 cycles -> exactly one TX_D_VLD with TX_P_DATA = 8'h5A; Ctrl_Busy returns to 0; both error flags stay 0.
- ALU_OUT = 16'hBEEF with OUT_Valid -> two strobes in order, 8'hEF then 8'hBE; the second strobe appears only after TX_Busy has fallen.
- RdData_Valid and OUT_Valid in the same cycle (RdData = 8'h11, ALU_OUT = 16'h2233) -> bytes 8'h33 then 8'h22 are sent; Drop_Err = 1; 8'h11 is never sent.
- TX_Busy held high before the first issue -> TX_D_VLD stays 0 until TX_Busy falls, then issues exactly once.
- TX_Busy never rises, ACK_TIMEOUT = 8 -> Tx_Err rises 8 cycles after the strobe; for an ALU result the second byte is still issued.
- RST asserted between the two bytes of 16'h1234 -> all outputs return to 0 immediately; after release, no strobe occurs until a new valid arrives.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller transmit path.
package sys_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ALU_W_DEF  = 16;
  // A buffered response is at most two bytes, so one index bit suffices.
  localparam int IDX_W      = 1;

endpackage

// File: rtl/tx_ack_timer.sv
// Clearable saturating up-counter used to bound the wait for UART TX busy.
module tx_ack_timer #(
  parameter int ACK_TIMEOUT = 255,
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles, holding at the limit instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // o_expire flags the edge at which the count reaches the limit.
  assign o_tc     = (r_count == LIMIT);
  assign o_expire = i_en && !i_clr && (r_count == LIMIT_M1);

endmodule

// File: rtl/sys_ctrl_tx_seq.sv
// Buffers one register-file or ALU response and hands it to UART TX byte by byte.
module sys_ctrl_tx_seq
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ALU_W       = ALU_W_DEF,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RdData,
  input  logic              RdData_Valid,
  input  logic [ALU_W-1:0]  ALU_OUT,
  input  logic              OUT_Valid,
  input  logic              TX_Busy,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD,
  output logic              Ctrl_Busy,
  output logic              Drop_Err,
  output logic              Tx_Err
);

  state_t            r_state;
  logic [ALU_W-1:0]  r_hold;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W:0]    r_nbytes;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_vld;
  logic              r_busy;
  logic              r_drop_err;
  logic              r_tx_err;

  logic              w_tmr_clr;
  logic              w_tmr_en;
  logic              w_tmr_tc;
  logic              w_tmr_expire;
  logic              w_more;
  logic [DATA_W-1:0] w_byte;

  assign w_tmr_clr = (r_state == ISSUE) && !TX_Busy;
  assign w_tmr_en  = (r_state == WAIT_ACK) && !TX_Busy;
  assign w_more    = ((IDX_W+1)'(r_idx) + (IDX_W+1)'(1)) < r_nbytes;
  assign w_byte    = (r_idx == IDX_W'(1)) ? r_hold[ALU_W-1:DATA_W] : r_hold[DATA_W-1:0];

  tx_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .o_tc    (w_tmr_tc),
    .o_expire(w_tmr_expire)
  );

  // Transfer sequencer with all outputs registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_idx      <= '0;
      r_nbytes   <= '0;
      r_tx_data  <= '0;
      r_tx_vld   <= 1'b0;
      r_busy     <= 1'b0;
      r_drop_err <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      r_tx_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (OUT_Valid) begin
            r_hold   <= ALU_OUT;
            r_nbytes <= (IDX_W+1)'(2);
            r_idx    <= '0;
            r_state  <= ISSUE;
            r_busy   <= 1'b1;
            if (RdData_Valid) begin
              r_drop_err <= 1'b1;
            end
          end else if (RdData_Valid) begin
            r_hold   <= {{(ALU_W-DATA_W){1'b0}}, RdData};
            r_nbytes <= (IDX_W+1)'(1);
            r_idx    <= '0;
            r_state  <= ISSUE;
            r_busy   <= 1'b1;
          end
        end
        ISSUE: begin
          if (!TX_Busy) begin
            r_tx_data <= w_byte;
            r_tx_vld  <= 1'b1;
            r_state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (TX_Busy) begin
            r_state <= WAIT_DONE;
          end else if (w_tmr_expire || w_tmr_tc) begin
            // No resend: treat the byte as delivered and move on.
            r_tx_err <= 1'b1;
            if (w_more) begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ISSUE;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        WAIT_DONE: begin
          if (!TX_Busy) begin
            if (w_more) begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ISSUE;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      // Responses arriving mid-transfer are lost; the hold register is untouched.
      if ((r_state != IDLE) && (RdData_Valid || OUT_Valid)) begin
        r_drop_err <= 1'b1;
      end
    end
  end

  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign Ctrl_Busy = r_busy;
  assign Drop_Err  = r_drop_err;
  assign Tx_Err    = r_tx_err;

endmodule

// File: tb/tb_sys_ctrl_tx_seq.sv
// Scoreboard bench for sys_ctrl_tx_seq with a behavioural UART TX busy model.
module tb_sys_ctrl_tx_seq;

  logic        CLK;
  logic        RST;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        OUT_Valid;
  logic        TX_Busy;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        Ctrl_Busy;
  logic        Drop_Err;
  logic        Tx_Err;

  int       n_checks;
  int       n_fail;
  int       vld_cnt;
  bit       model_en;
  bit       force_busy;
  int       model_hold;
  bit [7:0] exp_q[$];

  sys_ctrl_tx_seq #(
    .DATA_W(8),
    .ALU_W(16),
    .ACK_TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .TX_Busy(TX_Busy),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .Ctrl_Busy(Ctrl_Busy), .Drop_Err(Drop_Err), .Tx_Err(Tx_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // UART model and scoreboard: busy rises one cycle after each strobe.
  initial begin : uart_model
    int cnt;
    bit pend;
    bit [7:0] exp;
    cnt = 0;
    pend = 1'b0;
    TX_Busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST !== 1'b1) begin
        cnt = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          pend = 1'b0;
          cnt = model_hold;
        end else if (cnt > 0) begin
          cnt--;
        end
        if (TX_D_VLD === 1'b1) begin
          vld_cnt++;
          n_checks++;
          if (TX_Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL vld_while_busy: TX_Busy=%b, required 0", TX_Busy);
          end
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_byte: got %h, required no strobe", TX_P_DATA);
          end else begin
            exp = exp_q.pop_front();
            if (TX_P_DATA !== exp) begin
              n_fail++;
              $display("FAIL byte_data: got %h, required %h", TX_P_DATA, exp);
            end
          end
          pend = model_en;
        end
      end
      TX_Busy = force_busy || (cnt > 0);
    end
  end

  task automatic strobe(input bit rv, input bit [7:0] rd, input bit av, input bit [15:0] alu);
    @(negedge CLK);
    RdData = rd; RdData_Valid = rv;
    ALU_OUT = alu; OUT_Valid = av;
    @(negedge CLK);
    RdData_Valid = 1'b0;
    OUT_Valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge CLK);
      if (Ctrl_Busy === 1'b0 && TX_Busy === 1'b0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: Ctrl_Busy=%b, required 0 within 300 cycles", name, Ctrl_Busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_bytes: %0d left, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #12;
    n_checks++;
    if ({TX_P_DATA, TX_D_VLD, Ctrl_Busy, Drop_Err, Tx_Err} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h vld=%b busy=%b drop=%b txerr=%b, required all 0",
               TX_P_DATA, TX_D_VLD, Ctrl_Busy, Drop_Err, Tx_Err);
    end
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (Ctrl_Busy !== 1'b0 || vld_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b strobes=%0d, required 0 and 0", Ctrl_Busy, vld_cnt);
    end
  endtask

  task automatic test_rd_single();
    int v0;
    v0 = vld_cnt;
    exp_q.push_back(8'h5A);
    strobe(1'b1, 8'h5A, 1'b0, 16'h0000);
    n_checks++;
    if (Ctrl_Busy !== 1'b1 || TX_D_VLD !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_capture: busy=%b vld=%b, required 1 and 0", Ctrl_Busy, TX_D_VLD);
    end
    @(negedge CLK);
    n_checks++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h5A) begin
      n_fail++;
      $display("FAIL rd_latency: vld=%b data=%h, required 1 and 5a", TX_D_VLD, TX_P_DATA);
    end
    @(negedge CLK);
    n_checks++;
    if (TX_D_VLD !== 1'b0 || TX_P_DATA !== 8'h5A) begin
      n_fail++;
      $display("FAIL rd_one_cycle: vld=%b data=%h, required 0 and 5a held", TX_D_VLD, TX_P_DATA);
    end
    wait_idle("rd");
    n_checks++;
    if (vld_cnt - v0 != 1 || Drop_Err !== 1'b0 || Tx_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_result: strobes=%0d drop=%b txerr=%b, required 1 0 0", vld_cnt - v0, Drop_Err, Tx_Err);
    end
  endtask

  task automatic test_alu();
    int v0;
    v0 = vld_cnt;
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    strobe(1'b0, 8'h00, 1'b1, 16'hBEEF);
    wait_idle("alu");
    n_checks++;
    if (vld_cnt - v0 != 2 || Drop_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_result: strobes=%0d drop=%b, required 2 and 0", vld_cnt - v0, Drop_Err);
    end
  endtask

  task automatic test_collision();
    int v0;
    v0 = vld_cnt;
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h22);
    strobe(1'b1, 8'h11, 1'b1, 16'h2233);
    wait_idle("collide");
    n_checks++;
    if (vld_cnt - v0 != 2 || Drop_Err !== 1'b1 || Tx_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_result: strobes=%0d drop=%b txerr=%b, required 2 1 0", vld_cnt - v0, Drop_Err, Tx_Err);
    end
  endtask

  task automatic test_busy_before();
    int v0;
    v0 = vld_cnt;
    force_busy = 1'b1;
    repeat (2) @(negedge CLK);
    exp_q.push_back(8'h77);
    strobe(1'b1, 8'h77, 1'b0, 16'h0000);
    repeat (10) @(negedge CLK);
    n_checks++;
    if (vld_cnt != v0 || Ctrl_Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_hold: strobes=%0d busy=%b, required 0 and 1", vld_cnt - v0, Ctrl_Busy);
    end
    force_busy = 1'b0;
    wait_idle("busy");
    n_checks++;
    if (vld_cnt - v0 != 1) begin
      n_fail++;
      $display("FAIL busy_release: strobes=%0d, required 1", vld_cnt - v0);
    end
  endtask

  task automatic test_timeout();
    int v0;
    int lat;
    v0 = vld_cnt;
    lat = -1;
    model_en = 1'b0;
    exp_q.push_back(8'hAB);
    exp_q.push_back(8'hCD);
    strobe(1'b0, 8'h00, 1'b1, 16'hCDAB);
    @(negedge CLK);
    n_checks++;
    if (TX_D_VLD !== 1'b1 || Tx_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_issue: vld=%b txerr=%b, required 1 and 0", TX_D_VLD, Tx_Err);
    end
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge CLK);
      if (Tx_Err === 1'b1) lat = i;
    end
    n_checks++;
    if (lat != 8) begin
      n_fail++;
      $display("FAIL tmo_latency: Tx_Err after %0d cycles, required 8", lat);
    end
    wait_idle("tmo");
    n_checks++;
    if (vld_cnt - v0 != 2 || Tx_Err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_result: strobes=%0d txerr=%b, required 2 and 1", vld_cnt - v0, Tx_Err);
    end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int v0;
    v0 = vld_cnt;
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    strobe(1'b0, 8'h00, 1'b1, 16'h1234);
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    #1;
    n_checks++;
    if ({TX_P_DATA, TX_D_VLD, Ctrl_Busy, Drop_Err, Tx_Err} !== 12'h000) begin
      n_fail++;
      $display("FAIL rstmid_outputs: data=%h vld=%b busy=%b drop=%b txerr=%b, required all 0",
               TX_P_DATA, TX_D_VLD, Ctrl_Busy, Drop_Err, Tx_Err);
    end
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (30) @(negedge CLK);
    n_checks++;
    if (vld_cnt - v0 != 1 || Ctrl_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: strobes=%0d busy=%b, required 1 and 0", vld_cnt - v0, Ctrl_Busy);
    end
    exp_q.push_back(8'h99);
    strobe(1'b1, 8'h99, 1'b0, 16'h0000);
    wait_idle("rstmid");
    n_checks++;
    if (vld_cnt - v0 != 2 || Drop_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_restart: strobes=%0d drop=%b, required 2 and 0", vld_cnt - v0, Drop_Err);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    vld_cnt = 0;
    model_en = 1'b1;
    force_busy = 1'b0;
    model_hold = 10;
    RdData = 8'h00;
    RdData_Valid = 1'b0;
    ALU_OUT = 16'h0000;
    OUT_Valid = 1'b0;
    test_reset();
    test_rd_single();
    test_alu();
    test_collision();
    test_busy_before();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
